// File: rtl/share_refresh_pipe.sv
// D-share, W-bit masked delay line of LAT register stages; items flagged for
// refresh are re-masked with fresh randomness on leaving stage RND_LAT.
module share_refresh_pipe #(
  parameter int D       = 2,
  parameter int W       = 1,
  parameter int LAT     = 4,
  parameter int RND_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 refresh,
  input  logic [D*W-1:0]       in_shares,
  input  logic [(D-1)*W-1:0]   rng,
  output logic [D*W-1:0]       out_shares,
  output logic                 done,
  output logic                 active,
  output logic [15:0]          done_cnt
);

  localparam int DW = D * W;

  // Stage 0 is the combinational input; stages 1..LAT are registered.
  logic          st_vld [0:LAT];
  logic          st_rf  [0:LAT];
  logic [DW-1:0] st_dat [0:LAT];

  // Refresh mask: r_0..r_{D-2} on the first D-1 shares, their XOR on the last,
  // so the XOR across all shares is preserved.
  logic [DW-1:0] mask;
  logic [W-1:0]  rsum;

  always_comb begin
    mask = '0;
    rsum = '0;
    for (int i = 0; i < D - 1; i++) begin
      mask[i*W +: W] = rng[i*W +: W];
      rsum           = rsum ^ rng[i*W +: W];
    end
    mask[(D-1)*W +: W] = rsum;
  end

  genvar gi;
  generate
    for (gi = 0; gi <= LAT; gi++) begin : g_stg
      if (gi == 0) begin : g_in
        assign st_vld[gi] = en;
        assign st_rf[gi]  = en & refresh;
        assign st_dat[gi] = en ? in_shares : '0;
      end else begin : g_reg
        logic          vld_q, vld_d;
        logic          rf_q, rf_d;
        logic [DW-1:0] dat_q, dat_d;

        // Bubbles carry all-zero data and a cleared refresh bit.
        always_comb begin
          vld_d = st_vld[gi-1];
          rf_d  = st_vld[gi-1] & st_rf[gi-1];
          dat_d = '0;
          if (st_vld[gi-1]) begin
            dat_d = st_dat[gi-1];
            if ((gi - 1 == RND_LAT) && st_rf[gi-1]) begin
              dat_d = st_dat[gi-1] ^ mask;
            end
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_q <= 1'b0;
            rf_q  <= 1'b0;
            dat_q <= '0;
          end else begin
            vld_q <= vld_d;
            rf_q  <= rf_d;
            dat_q <= dat_d;
          end
        end

        assign st_vld[gi] = vld_q;
        assign st_rf[gi]  = rf_q;
        assign st_dat[gi] = dat_q;
      end
    end
  endgenerate

  assign out_shares = st_dat[LAT];
  assign done       = st_vld[LAT];
  assign active     = st_vld[RND_LAT] & st_rf[RND_LAT];

  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (done && (done_cnt_q != 16'hFFFF)) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;

endmodule

// File: doc/share_refresh_pipe.md
# share_refresh_pipe

Parametrised masked test pipeline for MATCHI composite verification. It carries a D-share, W-bit masked value through LAT register stages. When refresh is enabled, it re-masks the value with fresh randomness at stage RND_LAT. It drives an exact `active` flag that is high only in the cycles where randomness is consumed. It is the multi-share, multi-bit, back-to-back-capable successor of the single-bit delay test design, and sits at top level as a PINI loopy-architecture test target.

## Interface
- D, 2: number of shares; D ≥ 2.
- W, 1: bits per share; W ≥ 1.
- LAT, 4: pipeline depth in register stages; LAT ≥ 1.
- RND_LAT, 1: cycle offset after `en` at which randomness is sampled; 0 ≤ RND_LAT ≤ LAT-1.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  accept strobe; one transaction per high cycle.
- refresh  in  1  1 = re-mask at stage RND_LAT; 0 = pure delay. Sampled with `en` and carried with the item.
- in_shares  in  D*W  input sharing; share i at bits [i*W +: W].
- rng  in  (D-1)*W  fresh randomness; r_j at bits [j*W +: W].
- out_shares  out  D*W  output sharing; valid when `done` = 1.
- done  out  1  output-valid flag.
- active  out  1  high exactly in cycles where `rng` is consumed.
- done_cnt  out  16  count of completed transactions, saturating.

## Operation
- Stage 0 is the combinational input. Stages 1..LAT are registers, each holding a valid bit, a refresh bit and D*W data bits.
- Every cycle, stage k+1 loads stage k. Stage 1 loads {en, refresh, in_shares}.
- Refresh step on the transfer from stage RND_LAT to stage RND_LAT+1, applied only if the item is valid and its refresh bit is 1:
  - shares 0..D-2: share_i ^= r_i.
  - share D-1: share_{D-1} ^= (r_0 ^ … ^ r_{D-2}).
  - The XOR of all shares is unchanged.
- If the item's refresh bit is 0, data passes unchanged and `rng` is ignored.
- Data of an invalid stage is forced to 0. Bubbles never carry stale shares.
- `out_shares` = stage LAT data. `done` = stage LAT valid bit.
- `active` = valid & refresh of the item at stage RND_LAT (combinational from stage state; stage 0 uses `en` & `refresh` when RND_LAT = 0).
- `done_cnt` increments by 1 on each cycle with `done` = 1 and holds at 0xFFFF.
- No back-pressure:
  - `en` may be high in consecutive cycles.
  - Each item is independent and its results appear in consecutive cycles.
  - `en` and `refresh` are don't-care with respect to in-flight items.

## Timing
- `en` = 1 in cycle t: `out_shares` are valid and `done` = 1 in cycle t+LAT, for exactly one cycle per item.
- Randomness for the item must be stable on `rng` in cycle t+RND_LAT. `active` = 1 in that cycle iff `refresh` was 1 at t.
- Throughput: one item per cycle.
- Reset (rst_n = 0, asynchronous, any time, including mid-flight):
  - All valid bits, refresh bits, data and `done_cnt` clear to 0 immediately.
  - Hence `done` = 0, `active` = 0 (unless RND_LAT = 0 with `en` & `refresh` high), and `out_shares` = 0.
  - In-flight items are discarded.
- First accepted `en` is the first cycle with rst_n = 1.
- Simultaneous `done` and saturation: the counter stays at 0xFFFF without wrap.

## Test plan
- D=2, W=8, LAT=4, RND_LAT=1, refresh=1:
  - Stimulus: `en` at t with shares {0xA5, 0x3C}; rng = 0x0F at t+1.
  - Required: `active` = 1 only at t+1; `done` = 1 only at t+4; out = {0xAA, 0x33}; unmasked XOR is 0x99.
- Same configuration, refresh=0:
  - Stimulus: shares {0xA5, 0x3C}, rng = 0xFF.
  - Required: `active` never 1; out = {0xA5, 0x3C} at t+4.
- D=3, W=4, LAT=4, RND_LAT=1:
  - Stimulus: shares {0x1, 0x2, 0x4}; rng = 0x53 (r0 = 0x3, r1 = 0x5).
  - Required: out = {0x2, 0x7, 0x2}; XOR = 0x7 = input XOR.
- Back-to-back:
  - Stimulus: `en` high at t, t+1, t+2 with distinct shares and refresh = 1, 0, 1.
  - Required: `done` high t+4..t+6 with matching data; `active` high at t+1 and t+3 only; `done_cnt` = 3.
- Reset mid-flight:
  - Stimulus: `en` at t; rst_n low during cycle t+2.
  - Required: `done`, `out_shares` and `done_cnt` go to 0 immediately; no `done` at t+4.
- Saturation:
  - Stimulus: force `done_cnt` near max with 65 540 back-to-back items.
  - Required: `done_cnt` = 0xFFFF and holds there.
